// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus: field widths, receiver state encoding
// and the nibble-XOR frame checksum used by both transmitters and receivers.
`timescale 1ns/1ps
package bus_pkg;

   localparam int ADDR_W    = 4;
   localparam int DATA_W    = 64;
   localparam int CRC_W     = 4;
   localparam int FRAME_LEN = 1 + ADDR_W + DATA_W + CRC_W;
   localparam int CNT_W     = 7;

   // Bit-counter values on the last bit of each field (counter starts at 0 on the first ADDR bit)
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(ADDR_W + DATA_W - 1);
   localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(ADDR_W + DATA_W + CRC_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      CRC  = 2'd3
   } rx_state_e;

   function automatic logic [CRC_W-1:0] nibble_xor(input logic [ADDR_W-1:0] addr,
                                                   input logic [DATA_W-1:0] data);
      logic [CRC_W-1:0] acc;
      acc = addr;
      for (int i = 0; i < DATA_W / CRC_W; i++) begin
         acc = acc ^ data[i*CRC_W +: CRC_W];
      end
      return acc;
   endfunction

endpackage

// File: rtl/bus_nibble_checksum.sv
// Serial nibble-XOR accumulator. Bits arrive MSB first; the register rotates left
// while XORing each bit in, so after every whole nibble it holds the XOR of all nibbles.
`timescale 1ns/1ps
import bus_pkg::*;

module bus_nibble_checksum (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             bit_in,
   output logic [CRC_W-1:0] sum
);

   logic [CRC_W-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clear) begin
         sum_d = '0;
      end else if (shift_en) begin
         sum_d = {sum_q[CRC_W-2:0], sum_q[CRC_W-1] ^ bit_in};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum = sum_q;

endmodule

// File: rtl/bus_receiver.sv
// Shared-bus receiver node: deserialises start/ADDR/DATA/CRC frames and delivers
// frames addressed to NODE_ADDR. CRC checking is built only with BUS_RECEIVER_CRC_CHECK_EN.
`timescale 1ns/1ps
import bus_pkg::*;

module bus_receiver #(
   parameter logic [ADDR_W-1:0] NODE_ADDR = 4'd1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              bus_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              crc_err,
   output logic              busy,
   output logic [7:0]        rx_count,
   output rx_state_e         dbg_state
);

   rx_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              match_q, match_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              data_valid_q, data_valid_d;
   logic              crc_err_q, crc_err_d;
   logic [7:0]        rx_count_q, rx_count_d;
   logic              crc_ok;

`ifdef BUS_RECEIVER_CRC_CHECK_EN
   logic [CRC_W-1:0]  crc_rx_q, crc_rx_d;
   logic [CRC_W-1:0]  checksum;

   bus_nibble_checksum u_checksum (
      .clock    (clock),
      .reset    (reset),
      .clear    (state_q == IDLE),
      .shift_en ((state_q == ADDR) || (state_q == DATA)),
      .bit_in   (bus_in),
      .sum      (checksum)
   );

   // Last CRC bit is still on the bus when the decision is made
   assign crc_ok = ({crc_rx_q[CRC_W-2:0], bus_in} == checksum);

   always_comb begin
      crc_rx_d = crc_rx_q;
      if (state_q == CRC) begin
         crc_rx_d = {crc_rx_q[CRC_W-2:0], bus_in};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         crc_rx_q <= '0;
      end else begin
         crc_rx_q <= crc_rx_d;
      end
   end
`else
   assign crc_ok = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      match_d      = match_q;
      shift_d      = shift_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      crc_err_d    = 1'b0;
      rx_count_d   = rx_count_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus_in) begin
               state_d = ADDR;
            end
         end
         ADDR: begin
            addr_d = {addr_q[ADDR_W-2:0], bus_in};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == ADDR_LAST) begin
               state_d = DATA;
               match_d = ({addr_q[ADDR_W-2:0], bus_in} == NODE_ADDR);
            end
         end
         DATA: begin
            shift_d = {shift_q[DATA_W-2:0], bus_in};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == DATA_LAST) begin
               state_d = CRC;
            end
         end
         CRC: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CRC_LAST) begin
               // Non-matching frames are walked to the end but leave outputs alone
               state_d = IDLE;
               if (match_q) begin
                  if (crc_ok) begin
                     data_out_d   = shift_q;
                     data_valid_d = 1'b1;
                     rx_count_d   = rx_count_q + 8'd1;
                  end else begin
                     crc_err_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         match_q      <= 1'b0;
         shift_q      <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         crc_err_q    <= 1'b0;
         rx_count_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         match_q      <= match_d;
         shift_q      <= shift_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         crc_err_q    <= crc_err_d;
         rx_count_q   <= rx_count_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign crc_err    = crc_err_q;
   assign busy       = (state_q != IDLE);
   assign rx_count   = rx_count_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_bus_receiver.sv
// Self-checking bench for bus_receiver: directed frames from the test plan plus
// randomised traffic, checked against a frame-level reference model and scoreboard.
`timescale 1ns/1ps
module tb_bus_receiver;
   import bus_pkg::*;

   localparam logic [3:0] NODE = 4'd1;

   // ---------------- clock / reset ----------------
   logic        clock = 1'b0;
   logic        reset;
   logic        bus_in;
   logic [63:0] data_out;
   logic        data_valid;
   logic        crc_err;
   logic        busy;
   logic [7:0]  rx_count;
   rx_state_e   dbg_state;

   always #5 clock = ~clock;

   bus_receiver #(.NODE_ADDR(NODE)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus_in     (bus_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .crc_err    (crc_err),
      .busy       (busy),
      .rx_count   (rx_count),
      .dbg_state  (dbg_state)
   );

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard / model ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] exp_q[$];
   logic [63:0] exp_data;
   logic [7:0]  exp_count;
   int          accepted;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] ref_crc(input logic [3:0] addr, input logic [63:0] data);
      logic [3:0] c;
      c = addr;
      for (int i = 0; i < 16; i++) begin
         c = c ^ 4'((data >> (4 * i)) & 64'hF);
      end
      return c;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      exp_data  = '0;
      exp_count = '0;
      accepted  = 0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input logic b);
      bus_in = b;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         step(1'b0);
         check("idle_valid", data_valid, 1'b0);
         check("idle_crc_err", crc_err, 1'b0);
         check("idle_busy", busy, 1'b0);
      end
   endtask

   task automatic send_frame(input logic [3:0] addr, input logic [63:0] data, input logic [3:0] crc);
      logic [71:0] bits;
      logic        exp_v;
      logic        exp_e;
      logic        hit;
      int          busy_hits;
      int          pulses;
      bits = {addr, data, crc};
      hit  = (addr == NODE);
`ifdef BUS_RECEIVER_CRC_CHECK_EN
      exp_v = hit && (crc == ref_crc(addr, data));
      exp_e = hit && (crc != ref_crc(addr, data));
`else
      exp_v = hit;
      exp_e = 1'b0;
`endif
      if (exp_v) begin
         exp_q.push_back(data);
         exp_count = exp_count + 8'd1;
         accepted++;
      end
      busy_hits = 0;
      pulses    = 0;
      step(1'b1);
      for (int i = 71; i >= 0; i--) begin
         busy_hits += int'(busy);
         pulses    += int'(data_valid) + int'(crc_err);
         step(bits[i]);
      end
      bus_in = 1'b0;
      check("busy_cycles", 64'(busy_hits), 64'd72);
      check("mid_frame_pulse", 64'(pulses), 64'd0);
      check("busy_end", busy, 1'b0);
      check("data_valid", data_valid, exp_v);
      check("crc_err", crc_err, exp_e);
      if (exp_v && exp_q.size() > 0) begin
         exp_data = exp_q.pop_front();
      end
      check("data_out", data_out, exp_data);
      check("rx_count", rx_count, exp_count);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_data_out"}, data_out, 64'd0);
      check({tag, "_valid"}, data_valid, 1'b0);
      check({tag, "_crc_err"}, crc_err, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_rx_count"}, rx_count, 8'd0);
      check({tag, "_state"}, dbg_state, IDLE);
   endtask

   // Start a matching frame, then hit reset in cycle t0+30
   task automatic abort_frame(input logic [63:0] data);
      logic [71:0] bits;
      bits = {NODE, data, ref_crc(NODE, data)};
      step(1'b1);
      for (int i = 71; i > 42; i--) begin
         step(bits[i]);
      end
      reset = 1'b1;
      step(1'b0);
      reset = 1'b0;
      model_reset();
      check_reset_state("mid_reset");
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0]  a;
      logic [63:0] d;
      logic [3:0]  c;
      reset  = 1'b1;
      bus_in = 1'b0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      check_reset_state("reset");
      reset = 1'b0;
      idle(2);

      // directed frames
      send_frame(4'd1, 64'h1, 4'h0);
      idle(1);
      send_frame(4'd2, 64'hFF, 4'hD);
      idle(1);
      send_frame(4'd1, 64'h1, 4'h1);
      idle(1);
      send_frame(4'd1, 64'hDEADBEEF_00000000, 4'h1);
      send_frame(4'd1, 64'h1, 4'h0);
      idle(1);

      // reset in the middle of a matching frame
      abort_frame(64'hCAFE_F00D_1234_5678);
      idle(3);
      send_frame(NODE, 64'h0123_4567_89AB_CDEF, ref_crc(NODE, 64'h0123_4567_89AB_CDEF));
      check("after_abort_count", rx_count, 8'd1);
      idle(1);

      // randomised traffic, gap of 0 gives back-to-back frames
      for (int n = 0; n < 40; n++) begin
         a = ($urandom_range(0, 1) == 1) ? NODE : 4'($urandom_range(0, 15));
         d = {$urandom, $urandom};
         c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : ref_crc(a, d);
         send_frame(a, d, c);
         idle($urandom_range(0, 2));
      end

      // counter wrap: 256 accepted frames from reset
      reset = 1'b1;
      step(1'b0);
      reset = 1'b0;
      model_reset();
      while (accepted < 256) begin
         d = {$urandom, $urandom};
         send_frame(NODE, d, ref_crc(NODE, d));
      end
      check("wrap_rx_count", rx_count, 8'd0);
      idle(1);
      check("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
